booth_dot_accumulator: RTL and testbench
========================================

BOOTH_DOT_ACCUMULATOR -- requirements
Module: booth_dot_accumulator

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, operand width of the upstream Booth pipeline; product width is 2*DATAWIDTH.
REQ-002 SHALL have parameter ACC_WIDTH, default 20, accumulator and result width; legal range is ACC_WIDTH >= 2*DATAWIDTH.
REQ-003 SHALL have parameter NUM_TERMS, default 4, products per dot-product; legal range is 2..255.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 CLK  in  1  clock; all state changes on the rising edge.
REQ-006 RSTn  in  1  asynchronous active-low reset.
REQ-007 prod_valid  in  1  prod_data is valid this cycle; already delay-aligned to the multiplier latency.
REQ-008 prod_data  in  2*DATAWIDTH  two's-complement signed product.
REQ-009 clr  in  1  synchronous clear of the accumulation in progress.
REQ-010 out_ready  in  1  consumer accepts out_data.
REQ-011 out_valid  out  1  out_data holds a completed dot-product.
REQ-012 out_data  out  ACC_WIDTH  signed dot-product result.
REQ-013 out_sat  out  1  saturation occurred while forming out_data.
REQ-014 overrun  out  1  sticky; a completed result was dropped.

Function
REQ-015 SHALL sign-extend each accepted product to ACC_WIDTH and add it to the accumulator.
REQ-016 SHALL keep a term counter 0..NUM_TERMS-1 that increments on each accepted product.
REQ-017 SHALL treat the product taken while count==NUM_TERMS-1 as the last term, then zero both accumulator and counter in that same edge.
REQ-018 SHALL load the final sum (acc + last product) into the output register on the edge that takes the last term; out_valid rises one cycle after that last product is presented.
REQ-019 SHALL use a double buffer: accumulation of the next group proceeds while a result is held, and prod_valid is never back-pressured.
REQ-020 SHALL transfer out_data on any cycle with out_valid && out_ready; out_valid falls on the next edge unless a new result loads on that same edge.
REQ-021 SHALL, on completion in the same cycle as a transfer, load the new result and keep out_valid high.
REQ-022 SHALL, on completion while out_valid && !out_ready, keep the old result, drop the new one, set overrun, and restart accumulation from zero.
REQ-023 SHALL give clr priority over prod_valid: zero the accumulator, counter and overrun, discard any same-cycle product, and leave the held out_valid/out_data untouched.
REQ-024 SHALL keep out_data, out_sat and out_valid stable while out_valid && !out_ready.

Reset
REQ-025 SHALL, while RSTn is low, force accumulator=0, counter=0, out_valid=0, out_data=0, out_sat=0 and overrun=0 immediately, independent of CLK.
REQ-026 SHALL discard any partial group on reset; the first accepted product after release is term 0.

Configuration
REQ-027 SHALL honour macro BOOTH_ACC_SATURATE_EN.
- Defined: each addition clamps to the ACC_WIDTH signed max or min on overflow, and a per-group flag records this; out_sat loads that flag with the result.
- Undefined: additions wrap modulo 2^ACC_WIDTH and out_sat is tied 0.

Structure
REQ-028 SHALL place the default DATAWIDTH, ACC_WIDTH and NUM_TERMS constants, and the signed product/accumulator typedefs, in shared package booth_pkg.
REQ-029 SHALL implement the add/clamp datapath in one sub-module, booth_sat_add, with its saturation logic selected by BOOTH_ACC_SATURATE_EN.
REQ-030 SHALL contain only the counter, the result/handshake control and the overrun flag at top level.

Verification
REQ-031 Products 3, -5, 100, 7 on consecutive cycles with out_ready=1 -> out_valid for exactly 1 cycle with out_data=105, one cycle after the 4th product.
REQ-032 With BOOTH_ACC_SATURATE_EN and ACC_WIDTH=17, four products of 16384 (-128*-128) -> out_data=65535, out_sat=1; without the macro -> out_data=-65536 (bit pattern 0x10000), out_sat=0.
REQ-033 out_ready=0, two full groups summing 10 then 20 -> out_data stays 10, overrun=1; raising out_ready for one cycle -> out_valid drops.
REQ-034 Held result 10, second group completes in the same cycle out_ready=1 -> out_valid stays 1, out_data=20, overrun=0.
REQ-035 Two products 50, 60, then clr, then products 1, 2, 3, 4 -> out_data=10.
REQ-036 RSTn pulsed low mid-group after 2 products -> all outputs 0 immediately; the next 4 products 1, 1, 1, 1 -> out_data=4.

Source files
------------

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Brief    : Shared defaults and signed types for the Booth dot-product block.
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_ACC_WIDTH = 20;
  localparam int DEF_NUM_TERMS = 4;

  typedef logic signed [2*DEF_DATAWIDTH-1:0] prod_t;
  typedef logic signed [DEF_ACC_WIDTH-1:0]   acc_t;

endpackage
`default_nettype wire

// File: rtl/booth_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : booth_sat_add
// Brief    : Sign-extending accumulator adder; clamps on overflow when
//            BOOTH_ACC_SATURATE_EN is defined, otherwise wraps.
// Revision : 1.0 - initial release
// ============================================================================
module booth_sat_add import booth_pkg::*; #(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int PROD_WIDTH = 2*DEF_DATAWIDTH
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [PROD_WIDTH-1:0] prod,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  sat
);

  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  assign w_prod_ext = ACC_WIDTH'($signed(prod));

`ifdef BOOTH_ACC_SATURATE_EN
  logic [ACC_WIDTH:0] w_wide;
  logic               w_ovf;

  // One guard bit: the two top bits disagree exactly when the signed add overflowed.
  assign w_wide = {acc[ACC_WIDTH-1], acc} + {w_prod_ext[ACC_WIDTH-1], w_prod_ext};
  assign w_ovf  = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];

  always_comb begin
    sum = w_wide[ACC_WIDTH-1:0];
    if (w_ovf) begin
      sum = w_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  assign sat = w_ovf;
`else
  assign sum = acc + w_prod_ext;
  assign sat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/booth_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : booth_dot_accumulator
// Brief    : Accumulates NUM_TERMS signed products into a double-buffered
//            dot-product result. Saturation via BOOTH_ACC_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module booth_dot_accumulator import booth_pkg::*; #(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int NUM_TERMS = DEF_NUM_TERMS
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   prod_valid,
  input  logic [2*DATAWIDTH-1:0] prod_data,
  input  logic                   clr,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic                   out_sat,
  output logic                   overrun
);

  localparam int                   PROD_WIDTH = 2*DATAWIDTH;
  localparam int                   CNT_WIDTH  = $clog2(NUM_TERMS);
  localparam logic [CNT_WIDTH-1:0] LAST_TERM  = CNT_WIDTH'(NUM_TERMS-1);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_grp_sat;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_add_sat;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_slot_free;

  booth_sat_add #(
    .ACC_WIDTH  (ACC_WIDTH),
    .PROD_WIDTH (PROD_WIDTH)
  ) u_add (
    .acc  (r_acc),
    .prod (prod_data),
    .sum  (w_sum),
    .sat  (w_add_sat)
  );

  assign w_accept    = prod_valid && !clr;
  assign w_last      = w_accept && (r_count == LAST_TERM);
  assign w_slot_free = !out_valid || out_ready;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_grp_sat <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A transfer empties the output slot unless a fresh result refills it below.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (clr) begin
        r_acc     <= '0;
        r_count   <= '0;
        r_grp_sat <= 1'b0;
        overrun   <= 1'b0;
      end else if (w_last) begin
        r_acc     <= '0;
        r_count   <= '0;
        r_grp_sat <= 1'b0;
        if (w_slot_free) begin
          out_valid <= 1'b1;
          out_data  <= w_sum;
          out_sat   <= r_grp_sat | w_add_sat;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (w_accept) begin
        r_acc     <= w_sum;
        r_count   <= r_count + CNT_WIDTH'(1);
        r_grp_sat <= r_grp_sat | w_add_sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_dot_accumulator
// Brief    : Directed scoreboard bench for booth_dot_accumulator (default
//            instance plus a 17-bit accumulator instance for overflow).
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_dot_accumulator;

  typedef struct {
    logic signed [31:0] data;
    logic               sat;
  } exp_t;

  logic        CLK;
  logic        RSTn;
  logic        prod_valid;
  logic [15:0] prod_data;
  logic        clr;
  logic        out_ready;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_sat;
  logic        overrun;

  logic        s_prod_valid;
  logic [15:0] s_prod_data;
  logic        s_clr;
  logic        s_out_ready;
  logic        s_out_valid;
  logic [16:0] s_out_data;
  logic        s_out_sat;
  logic        s_overrun;

  int   total;
  int   bad;
  exp_t sb[$];

  booth_dot_accumulator #(
    .DATAWIDTH (8),
    .ACC_WIDTH (20),
    .NUM_TERMS (4)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .clr        (clr),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .overrun    (overrun)
  );

  booth_dot_accumulator #(
    .DATAWIDTH (8),
    .ACC_WIDTH (17),
    .NUM_TERMS (4)
  ) dut_s (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .prod_valid (s_prod_valid),
    .prod_data  (s_prod_data),
    .clr        (s_clr),
    .out_ready  (s_out_ready),
    .out_valid  (s_out_valid),
    .out_data   (s_out_data),
    .out_sat    (s_out_sat),
    .overrun    (s_overrun)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic prod(input int d);
    prod_valid = 1'b1;
    prod_data  = 16'(d);
    cyc();
    prod_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic group(input int a, input int b, input int c, input int d,
                       input bit expect_out);
    exp_t e;
    if (expect_out) begin
      e.data = a + b + c + d;
      e.sat  = 1'b0;
      sb.push_back(e);
    end
    prod(a);
    prod(b);
    prod(c);
    prod(d);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=no_expectation expected=queued_result", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'b0, out_valid}, 1);
      chk({tag, "_data"}, $signed(out_data), e.data);
      chk({tag, "_sat"}, {31'b0, out_sat}, {31'b0, e.sat});
    end
  endtask

  initial begin
    exp_t es;
    total        = 0;
    bad          = 0;
    RSTn         = 1'b0;
    prod_valid   = 1'b0;
    prod_data    = '0;
    clr          = 1'b0;
    out_ready    = 1'b1;
    s_prod_valid = 1'b0;
    s_prod_data  = '0;
    s_clr        = 1'b0;
    s_out_ready  = 1'b1;
    #2;
    chk("rst_valid",   {31'b0, out_valid}, 0);
    chk("rst_data",    $signed(out_data), 0);
    chk("rst_sat",     {31'b0, out_sat}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    idle(2);
    RSTn = 1'b1;
    idle(1);

    // Basic group, one-cycle valid with ready high
    group(3, -5, 100, 7, 1'b1);
    check_out("basic");
    idle(1);
    chk("basic_drop", {31'b0, out_valid}, 0);

    // Negative result with gaps between products
    es.data = -400; es.sat = 1'b0; sb.push_back(es);
    prod(-100); idle(2); prod(-100); prod(-100); idle(1); prod(-100);
    check_out("neg_gaps");
    idle(1);

    // Overrun: second result dropped while held
    out_ready = 1'b0;
    group(1, 2, 3, 4, 1'b1);
    check_out("held10");
    group(2, 4, 6, 8, 1'b0);
    chk("ovr_data",    $signed(out_data), 10);
    chk("ovr_valid",   {31'b0, out_valid}, 1);
    chk("ovr_flag",    {31'b0, overrun}, 1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("ovr_release", {31'b0, out_valid}, 0);
    chk("ovr_sticky",  {31'b0, overrun}, 1);

    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("clr_overrun", {31'b0, overrun}, 0);

    // Completion coinciding with transfer of the held result
    group(1, 2, 3, 4, 1'b1);
    check_out("held_again");
    es.data = 20; es.sat = 1'b0; sb.push_back(es);
    prod(5); prod(5); prod(5);
    out_ready = 1'b1;
    prod(5);
    check_out("swap");
    chk("swap_overrun", {31'b0, overrun}, 0);
    idle(1);
    chk("swap_drop", {31'b0, out_valid}, 0);

    // clr discards the partial group and a same-cycle product
    prod(50); prod(60);
    clr = 1'b1; prod_valid = 1'b1; prod_data = 16'd99;
    cyc();
    clr = 1'b0; prod_valid = 1'b0;
    group(1, 2, 3, 4, 1'b1);
    check_out("clr_group");
    idle(1);

    // Asynchronous reset mid-group while a result is held
    out_ready = 1'b0;
    group(7, 7, 7, 7, 1'b1);
    check_out("pre_reset");
    prod(1); prod(2);
    RSTn = 1'b0;
    #2;
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_data",  $signed(out_data), 0);
    chk("arst_sat",   {31'b0, out_sat}, 0);
    RSTn = 1'b1;
    out_ready = 1'b1;
    idle(1);
    group(1, 1, 1, 1, 1'b1);
    check_out("post_reset");
    idle(1);

    // Overflow on the 17-bit accumulator instance
    for (int i = 0; i < 4; i++) begin
      s_prod_valid = 1'b1;
      s_prod_data  = 16'd16384;
      cyc();
    end
    s_prod_valid = 1'b0;
    chk("ovf_valid", {31'b0, s_out_valid}, 1);
`ifdef BOOTH_ACC_SATURATE_EN
    chk("ovf_data", $signed(s_out_data), 65535);
    chk("ovf_sat",  {31'b0, s_out_sat}, 1);
`else
    chk("ovf_data", $signed(s_out_data), -65536);
    chk("ovf_sat",  {31'b0, s_out_sat}, 0);
`endif
    idle(1);
    chk("ovf_drop", {31'b0, s_out_valid}, 0);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
